tdm_mux: RTL and testbench
==========================

# tdm_mux

Parametrised, registered N-channel, W-bit multiplexer with two modes: manual select and automatic round-robin scan with a programmable dwell time per channel. It generalises the combinational 8:1 single-bit multiplexer into a clocked block. It drives time-multiplexed outputs on the iCE40 board, for example LED/7-segment digit scanning or serial probing of several signals. The output, the active channel index and the event strobes are all registered.

## Interface
- `W`, 1: data width per channel (≥1).
- `N`, 8: number of channels (≥2).
- `DWELL`, 12: cycles spent on each channel in scan mode (≥1).
- `SW`, `$clog2(N)`: select/channel index width; derived, not overridden.

Ports:
- `clk` in 1: single system clock (12 MHz on board).
- `rstn` in 1: reset, asynchronous assert, active-low.
- `d` in N*W: flattened channel data; channel i occupies `d[i*W +: W]`.
- `mode` in 1: 0 = manual (follow `sel`), 1 = scan.
- `sel` in SW: manual channel select.
- `hold` in 1: in scan mode, freezes the dwell counter and channel; ignored in manual mode.
- `z` out W: registered selected data.
- `ch` out SW: channel currently selected.
- `strobe` out 1: one-cycle pulse in the cycle after `ch` changes value.
- `wrap` out 1: one-cycle pulse, coincident with `strobe`, when scan moves from channel N-1 to 0.

## Operation
- **Reset values** (`rstn` low, immediate, no clock needed):
  - `z`=0, `ch`=0, `strobe`=0, `wrap`=0.
  - Dwell counter=0, state=MANUAL.
- **FSM states**: MANUAL, SCAN.
  - MANUAL→SCAN when `mode`=1 is sampled.
  - SCAN→MANUAL when `mode`=0 is sampled.
  - The state follows `mode` with one cycle of delay.
- **Common rule**: at every edge, `ch` loads `ch_next` and `z` loads `d[ch_next]`. `z` is never taken from the old `ch`.
- **MANUAL**:
  - `ch_next` = `sel` when `sel` < N.
  - When `sel` ≥ N (N not a power of two), `ch_next` = `ch`, i.e. the value is held.
  - Dwell counter is held at 0.
- **SCAN**:
  - Dwell counter counts 0..DWELL-1.
  - At count DWELL-1 with `hold`=0, the counter returns to 0 and `ch_next` = `ch`+1, wrapping N-1→0.
  - Otherwise `ch_next` = `ch` and the counter increments.
- **Hold**: `hold`=1 in SCAN freezes the counter and `ch`. `z` keeps tracking `d[ch]` every cycle. On release, the remaining dwell completes.
- **Mode entry**:
  - Entering SCAN starts from the current `ch` with the counter at 0. That channel gets a full DWELL.
  - Entering MANUAL, the first edge in the MANUAL state loads `sel`.
- **Strobes**:
  - `strobe`=1 for exactly one cycle after any edge where `ch` changed.
  - No strobe is generated after reset or when the loaded value equals the old `ch`.
  - `wrap` pulses only in SCAN, on the N-1→0 transition.
- **DWELL=1**: `ch` advances on every edge and `strobe` stays high continuously while scanning.
- Counter width is `$clog2(DWELL)`, with a minimum of 1 bit. No arithmetic overflow is possible.

## Timing
- `z` latency is 1 cycle from `d`/`sel` to output.
- All outputs are registered. There is no combinational path from input to output.
- Scan period is N×DWELL cycles. With `hold` low, `wrap` recurs every N×DWELL cycles.
- Reset asserted mid-scan aborts immediately. After `rstn` deasserts, the first edge behaves as MANUAL with `ch`=0.
- A simultaneous `mode` toggle and dwell expiry is resolved by the state in force at that edge. The mode change takes effect on the next edge.

## Structure
- Shared include `mux_defs.vh` holds:
  - the mode encodings (`MODE_MANUAL`=0, `MODE_SCAN`=1);
  - the FSM state encodings;
  - a helper macro for the minimum-1 counter width.
- Natural sub-module `dwell_counter`: parametrised by DWELL, with inputs `en`/`clr` and a `tc` output.
- Channel select and FSM stay in `tdm_mux`.

## Test plan
Instance N=8, W=4, DWELL=3 with `d[i]`=i+1 unless noted.
1. **Async reset**: pull `rstn` low between clock edges mid-scan → `z`=0, `ch`=0 and strobes 0 immediately; after release, `z` stays 0 until first edge gives `z`=1.
2. **Manual**: `sel`=5 → one edge later `ch`=5, `z`=6, `strobe` high for 1 cycle. Change `d[5]` to 0xA with `sel` held → next edge `z`=0xA, no strobe.
3. **Scan**: `mode`=1 from `ch`=0 → `ch` runs 0,0,0,1,1,1…7,7,7,0, `strobe` every 3 cycles, `wrap` exactly once per 24 cycles at 7→0.
4. **Hold**: assert `hold` for 5 cycles at `ch`=2, count=1 → `ch` stays 2, `z` follows a changing `d[2]`, and `ch` advances to 3 two cycles after release.
5. **Mode switch**:
   - SCAN at `ch`=3 → `mode`=0 with `sel`=6 → `ch`=6 and `strobe` on the second edge.
   - `mode`=1 again → `ch` holds 6 for 3 cycles, then moves to 7.
6. **Non-power-of-two**: instance N=6 with `sel`=7 → `ch` and `z` hold their values, no strobe. Scan wraps 5→0 with `wrap`.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the time-division multiplexer: mode and state
// encodings plus the dwell-counter width helper.
package tdm_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [0:0] {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Counter width for a 0..dwell-1 range, never narrower than one bit.
    function automatic int cnt_width(input int dwell);
        if (dwell <= 2) begin
            return 1;
        end else begin
            return $clog2(dwell);
        end
    endfunction

endpackage

// File: rtl/tdm_mux_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last count on tc,
// and is forced to zero by clr.
module dwell_counter
    import tdm_mux_pkg::*;
#(
    parameter int DWELL = 12
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_r;

    assign tc = (cnt_r == LAST);

    // Count register: clear wins, wraps to zero after the last count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en) begin
            cnt_r <= tc ? {CW{1'b0}} : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/tdm_mux.sv
// Registered N-channel, W-bit multiplexer with manual select and a
// round-robin scan mode that dwells DWELL cycles on each channel.
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter  int W     = 1,
    parameter  int N     = 8,
    parameter  int DWELL = 12,
    localparam int SW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N*W-1:0] d,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic           hold,
    output logic [W-1:0]   z,
    output logic [SW-1:0]  ch,
    output logic           strobe,
    output logic           wrap
);

    localparam logic [SW:0]   N_EXT   = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

    state_t        state_r;
    logic [SW-1:0] ch_next_s;
    logic          wrap_next_s;
    logic          tc_s;
    logic          cnt_en_s;
    logic          cnt_clr_s;
    logic [W-1:0]  d_arr_s [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign d_arr_s[i] = d[i*W +: W];
    end

    assign cnt_clr_s = (state_r == ST_MANUAL);
    assign cnt_en_s  = (state_r == ST_SCAN) && !hold;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rstn (rstn),
        .en   (cnt_en_s),
        .clr  (cnt_clr_s),
        .tc   (tc_s)
    );

    // Next channel: manual follows a valid sel, scan advances on dwell expiry.
    always_comb begin
        ch_next_s   = ch;
        wrap_next_s = 1'b0;
        case (state_r)
            ST_MANUAL: begin
                if ({1'b0, sel} < N_EXT) begin
                    ch_next_s = sel;
                end else begin
                    ch_next_s = ch;
                end
            end
            ST_SCAN: begin
                if (tc_s && !hold) begin
                    if (ch == LAST_CH) begin
                        ch_next_s   = {SW{1'b0}};
                        wrap_next_s = 1'b1;
                    end else begin
                        ch_next_s   = ch + SW'(1);
                    end
                end else begin
                    ch_next_s = ch;
                end
            end
            default: begin
                ch_next_s = ch;
            end
        endcase
    end

    // State and all outputs; z always samples the channel being loaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_MANUAL;
            ch      <= {SW{1'b0}};
            z       <= {W{1'b0}};
            strobe  <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_r <= (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
            ch      <= ch_next_s;
            z       <= d_arr_s[ch_next_s];
            strobe  <= (ch_next_s != ch);
            wrap    <= wrap_next_s;
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Scoreboard bench for tdm_mux: an 8-channel and a 6-channel instance,
// both W=4, DWELL=3, with d[i]=i+1 unless a test overrides it.
module tb_tdm_mux;

    localparam int W = 4;
    localparam int N = 8;
    localparam int N6 = 6;
    localparam int DWELL = 3;

    typedef struct packed {
        logic [3:0] z;
        logic [2:0] ch;
        logic       strobe;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic [N*W-1:0]  d;
    logic            mode;
    logic [2:0]      sel;
    logic            hold;
    logic [W-1:0]    z;
    logic [2:0]      ch;
    logic            strobe;
    logic            wrap;

    logic [N6*W-1:0] d6;
    logic            mode6;
    logic [2:0]      sel6;
    logic            hold6;
    logic [W-1:0]    z6;
    logic [2:0]      ch6;
    logic            strobe6;
    logic            wrap6;

    exp_t q8[$];
    exp_t q6[$];
    exp_t m8;
    exp_t m6;
    int total = 0;
    int bad = 0;

    tdm_mux #(.W(W), .N(N), .DWELL(DWELL)) dut (
        .clk(clk), .rstn(rstn), .d(d), .mode(mode), .sel(sel), .hold(hold),
        .z(z), .ch(ch), .strobe(strobe), .wrap(wrap)
    );

    tdm_mux #(.W(W), .N(N6), .DWELL(DWELL)) dut6 (
        .clk(clk), .rstn(rstn), .d(d6), .mode(mode6), .sel(sel6), .hold(hold6),
        .z(z6), .ch(ch6), .strobe(strobe6), .wrap(wrap6)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setd8(input int i, input int v);
        d[i*W +: W] = 4'(v);
    endtask

    task automatic exp8(input int ez, input int ec, input int es, input int ew);
        q8.push_back(exp_t'{4'(ez), 3'(ec), 1'(es), 1'(ew)});
        @(negedge clk);
    endtask

    task automatic exp6(input int ez, input int ec, input int es, input int ew);
        q6.push_back(exp_t'{4'(ez), 3'(ec), 1'(es), 1'(ew)});
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per edge for each instance that has one queued.
    always @(posedge clk) begin
        #1;
        if (q8.size() != 0) begin
            m8 = q8.pop_front();
            chk("z8", int'(z), int'(m8.z));
            chk("ch8", int'(ch), int'(m8.ch));
            chk("strobe8", int'(strobe), int'(m8.strobe));
            chk("wrap8", int'(wrap), int'(m8.wrap));
        end
        if (q6.size() != 0) begin
            m6 = q6.pop_front();
            chk("z6", int'(z6), int'(m6.z));
            chk("ch6", int'(ch6), int'(m6.ch));
            chk("strobe6", int'(strobe6), int'(m6.strobe));
            chk("wrap6", int'(wrap6), int'(m6.wrap));
        end
    end

    initial begin
        int cb;
        int ca;
        rstn = 1'b1;
        mode = 1'b0;
        sel = 3'd0;
        hold = 1'b0;
        mode6 = 1'b0;
        sel6 = 3'd0;
        hold6 = 1'b0;
        for (int i = 0; i < N; i++) setd8(i, i + 1);
        for (int i = 0; i < N6; i++) d6[i*W +: W] = 4'(i + 1);

        // Power-on reset without any clock edge.
        #1 rstn = 1'b0;
        #1;
        chk("rst_z", int'(z), 0);
        chk("rst_ch", int'(ch), 0);
        chk("rst_strobe", int'(strobe), 0);
        chk("rst_wrap", int'(wrap), 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("rel_z", int'(z), 0);
        exp8(1, 0, 0, 0);

        // Manual select and data tracking.
        sel = 3'd5;
        exp8(6, 5, 1, 0);
        exp8(6, 5, 0, 0);
        setd8(5, 10);
        exp8(10, 5, 0, 0);
        setd8(5, 6);
        exp8(6, 5, 0, 0);
        sel = 3'd0;
        exp8(1, 0, 1, 0);

        // Scan from ch 0 through a full wrap, ending at ch 2 with count 1.
        mode = 1'b1;
        exp8(1, 0, 0, 0);
        for (int k = 0; k <= 30; k++) begin
            cb = (k / 3) % 8;
            if (k % 3 == 2) begin
                ca = (cb + 1) % 8;
                exp8(ca + 1, ca, 1, (cb == 7) ? 1 : 0);
            end else begin
                exp8(cb + 1, cb, 0, 0);
            end
        end

        // Hold for 5 cycles while d[2] changes, then finish the dwell.
        hold = 1'b1;
        for (int j = 0; j < 5; j++) begin
            setd8(2, 8 + j);
            exp8(8 + j, 2, 0, 0);
        end
        hold = 1'b0;
        setd8(2, 3);
        exp8(3, 2, 0, 0);
        exp8(4, 3, 1, 0);

        // Back to manual at ch 3, then re-enter scan from ch 6.
        mode = 1'b0;
        sel = 3'd6;
        exp8(4, 3, 0, 0);
        exp8(7, 6, 1, 0);
        mode = 1'b1;
        exp8(7, 6, 0, 0);
        exp8(7, 6, 0, 0);
        exp8(7, 6, 0, 0);
        exp8(8, 7, 1, 0);

        // Mode drop coincident with dwell expiry: scan still wraps, manual next edge.
        exp8(8, 7, 0, 0);
        exp8(8, 7, 0, 0);
        mode = 1'b0;
        sel = 3'd1;
        exp8(1, 0, 1, 1);
        exp8(2, 1, 1, 0);

        // Reset between edges in the middle of a scan with strobe high.
        mode = 1'b1;
        exp8(2, 1, 0, 0);
        exp8(2, 1, 0, 0);
        exp8(2, 1, 0, 0);
        exp8(3, 2, 1, 0);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_z", int'(z), 0);
        chk("mid_rst_ch", int'(ch), 0);
        chk("mid_rst_strobe", int'(strobe), 0);
        chk("mid_rst_wrap", int'(wrap), 0);
        sel = 3'd0;
        rstn = 1'b1;
        #1 chk("mid_rel_z", int'(z), 0);
        exp8(1, 0, 0, 0);
        exp8(1, 0, 0, 0);
        exp8(1, 0, 0, 0);
        exp8(2, 1, 1, 0);
        mode = 1'b0;

        // Six-channel instance: out-of-range select holds, scan wraps 5 -> 0.
        sel6 = 3'd4;
        exp6(5, 4, 1, 0);
        sel6 = 3'd7;
        exp6(5, 4, 0, 0);
        exp6(5, 4, 0, 0);
        sel6 = 3'd6;
        exp6(5, 4, 0, 0);
        sel6 = 3'd5;
        mode6 = 1'b1;
        exp6(6, 5, 1, 0);
        exp6(6, 5, 0, 0);
        exp6(6, 5, 0, 0);
        exp6(1, 0, 1, 1);
        exp6(1, 0, 0, 0);

        @(negedge clk);
        chk("drain", q8.size() + q6.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
